// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: shift-add significand product, round-to-nearest-even, special values.
// Define FPMUL_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef FPMUL_FLAGS_EN
  output logic [3:0]         flags,
`endif
  output logic [EXP_W+MAN_W:0] out
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 1;
  localparam int PW = 2 * N;
  localparam int CW = $clog2(N + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};

  typedef enum logic [1:0] {IDLE, MULT, RND, DONE} state_t;

  state_t                 state, state_nx;
  logic [N-1:0]           a_man;
  logic [PW-1:0]          prod;
  logic [CW-1:0]          cnt;
  logic                   sign_q;
  logic signed [XW-1:0]   exp_q;
  logic [W-1:0]           out_q;
  logic                   out_valid_q;

  // Operand decode; exponent-zero inputs are treated as zero (no subnormals).
  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     frac_a, frac_b;
  logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic                 sign_in, spec_invalid, spec_inf, special;
  logic signed [XW-1:0] exp_in;
  logic [W-1:0]         spec_res;

  assign exp_a   = in1[MAN_W +: EXP_W];
  assign exp_b   = in2[MAN_W +: EXP_W];
  assign frac_a  = in1[MAN_W-1:0];
  assign frac_b  = in2[MAN_W-1:0];
  assign zero_a  = (exp_a == '0);
  assign zero_b  = (exp_b == '0);
  assign inf_a   = (exp_a == EXP_ONES) && (frac_a == '0);
  assign inf_b   = (exp_b == EXP_ONES) && (frac_b == '0);
  assign nan_a   = (exp_a == EXP_ONES) && (frac_a != '0);
  assign nan_b   = (exp_b == EXP_ONES) && (frac_b != '0);
  assign sign_in = in1[W-1] ^ in2[W-1];
  assign exp_in  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

  assign spec_invalid = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
  assign spec_inf     = inf_a | inf_b;
  assign special      = spec_invalid | spec_inf | zero_a | zero_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    spec_res = {sign_in, {(W-1){1'b0}}};
    if (spec_invalid)  spec_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    else if (spec_inf) spec_res = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
  end

  // One shift-add step: conditionally add A to the upper half, shift the whole product right.
  logic [N:0] add_sum;
  assign add_sum = {1'b0, prod[PW-1:N]} + (prod[0] ? {1'b0, a_man} : '0);

  // Normalise and round-to-nearest-even using guard and sticky.
  logic                 hi, guard, sticky, round_up, ovf, unf;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       frac_rnd;
  logic signed [XW-1:0] exp_rnd;
  logic [W-1:0]         rnd_res;

  assign hi = prod[PW-1];

  always_comb begin
    frac_t = prod[PW-3 -: MAN_W];
    guard  = prod[MAN_W-1];
    sticky = |prod[MAN_W-2:0];
    if (hi) begin
      frac_t = prod[PW-2 -: MAN_W];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
    end
  end

  assign round_up = guard & (sticky | frac_t[0]);
  assign frac_rnd = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
  assign exp_rnd  = exp_q + $signed({{(XW-1){1'b0}}, hi})
                          + $signed({{(XW-1){1'b0}}, frac_rnd[MAN_W]});
  assign ovf      = !exp_rnd[XW-1] && (exp_rnd[XW-2:0] >= {1'b0, EXP_ONES});
  assign unf      = exp_rnd[XW-1] || (exp_rnd == '0);

  always_comb begin
    rnd_res = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    if (ovf)      rnd_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
    else if (unf) rnd_res = {sign_q, {(W-1){1'b0}}};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = special ? DONE : MULT;
      MULT:    if (cnt == CW'(1)) state_nx = RND;
      RND:     state_nx = DONE;
      DONE:    if (out_valid_q && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_man       <= '0;
      prod        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_man  <= {1'b1, frac_a};
          prod   <= {{N{1'b0}}, 1'b1, frac_b};
          cnt    <= CW'(N);
          sign_q <= sign_in;
          exp_q  <= exp_in;
          if (special) out_q <= spec_res;
        end
        MULT: begin
          prod <= {add_sum, prod[N-1:1]};
          cnt  <= cnt - CW'(1);
        end
        RND:  out_q <= rnd_res;
        DONE: begin
          // Result settles one cycle in DONE before it is presented.
          if (!out_valid_q)   out_valid_q <= 1'b1;
          else if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FPMUL_FLAGS_EN
  logic [3:0] flags_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else if (state == IDLE && in_valid && special) flags_q <= {spec_invalid, 3'b000};
    else if (state == IDLE && in_valid)            flags_q <= '0;
    else if (state == RND) flags_q <= {1'b0, ovf, unf & ~ovf, guard | sticky | ovf | unf};
  end
  assign flags = flags_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq (defaults): arithmetic reference model, random and directed operands.
module tb_fp_mul_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]   flags;
`endif

  fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FPMUL_FLAGS_EN
    .flags(flags),
`endif
    .out(out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        special;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact integer product, then round by remainder comparison against half an ulp.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    r.special = 1'b1;
    r.flg = 4'b0000;
    r.res = {s, 31'h0};
    if (na || nb || (ia && zb) || (za && ib)) begin
      r.res = 32'h7FC00000;
      r.flg = 4'b1000;
    end else if (ia || ib) begin
      r.res = {s, 8'hFF, 23'h0};
    end else if (!(za || zb)) begin
      r.special = 1'b0;
      ma = 64'(a[22:0]) + (64'd1 << 23);
      mb = 64'(b[22:0]) + (64'd1 << 23);
      p  = ma * mb;
      e  = ea + eb - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e++;
      end
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0};
        r.flg = 4'b0101;
      end else if (e <= 0) begin
        r.res = {s, 31'h0};
        r.flg = 4'b0011;
      end else begin
        r.res = {s, e[7:0], q[22:0]};
        r.flg = {3'b000, rem != 0};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0, 1: v[30:23] = 8'($urandom_range(100, 154));
      2:    v[30:23] = 8'($urandom_range(1, 254));
      3:    v[30:23] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(230, 254))
                                                   : 8'($urandom_range(1, 20));
      4: begin
        v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) != 0) v[22:0] = '0;
      end
      default: v[30:23] = 8'h00;
    endcase
    return v;
  endfunction

  // All stimulus tasks start and end at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit fixed, input logic [31:0] kres, input logic [3:0] kflg);
    exp_t ex;
    int n;
    ex = model(a, b);
    if (fixed) begin
      ex.res = kres;
      ex.flg = kflg;
    end
    wait_ready();
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    sb.push_back(ex);
    check("accepted", in_ready, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, ex.special ? 1 : MAN_W + 3);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pops the scoreboard on each hand-off, checks the output holds while stalled.
  initial begin
    logic [31:0] held;
    bit have;
    exp_t x;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (out_valid) begin
        if (have) check("hold_stable", out, held);
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h with no operation outstanding", out);
          end else begin
            x = sb.pop_front();
            check("result", out, x.res);
`ifdef FPMUL_FLAGS_EN
            check("flags", 32'(flags), 32'(x.flg));
`endif
          end
          have = 1'b0;
        end else begin
          held = out;
          have = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t bp;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid_after", out_valid, 0);

    issue(32'h40000000, 32'h3F800000, 1, 32'h40000000, 4'b0000);
    issue(32'h40000000, 32'h40000000, 1, 32'h40800000, 4'b0000);
    issue(32'h40A80000, 32'h40000000, 1, 32'h41280000, 4'b0000);
    issue(32'h7F800000, 32'h00000000, 1, 32'h7FC00000, 4'b1000);
    issue(32'hFF800000, 32'h40000000, 1, 32'hFF800000, 4'b0000);
    issue(32'h7F000000, 32'h7F000000, 1, 32'h7F800000, 4'b0101);
    issue(32'h00800000, 32'h00800000, 1, 32'h00000000, 4'b0011);
    issue(32'h3F800001, 32'h3F800001, 1, 32'h3F800002, 4'b0001);
    issue(32'h3FC00000, 32'h3F800001, 0, '0, '0);
    issue(32'h3FC00000, 32'h3F800003, 0, '0, '0);

    // Backpressure: result must hold and new operands must be refused.
    ready_force = 1'b0;
    @(posedge clk); #1;
    bp = model(32'h40000000, 32'h40000000);
    issue(32'h40000000, 32'h40000000, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in1 = $urandom;
      in2 = $urandom;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, bp.res);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ready_force = 1'b1;

    // Reset in the middle of MULT discards the operation.
    wait_ready();
    in1 = 32'h40400000;
    in2 = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out", out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_result", out_valid, 0);
    issue(32'h40000000, 32'h40000000, 1, 32'h40800000, 4'b0000);

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) issue(rand_op(), rand_op(), 0, '0, '0);
    rand_ready = 1'b0;
    ready_force = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
